pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Detects load-use hazards in ID,
//  squashes wrong-path instructions on EX-resolved redirects, and freezes the pipe while data
//  memory is busy. Drives FlushE into the ID/EX control-masking mux and the stall/flush pins of
//  every pipeline register. Adds a data-memory wait watchdog and saturating perf counters.
// PARAMETERS
//  TIMEOUT_CYCLES  255  consecutive DMemBusy cycles that trip the watchdog (must be >= 2)
//  CNT_W           32   width of StallCount / FlushCount
//  REG_AW          5    register-address width
// PORTS
//  CLK          in   1       single pipeline clock, all state on rising edge
//  RESET        in   1       synchronous, active-high
//  MemReadE     in   1       EX instruction is a load (already masked)
//  RdE          in   REG_AW  EX destination register
//  Rs1D, Rs2D   in   REG_AW  ID source registers
//  Rs1UsedD     in   1       ID instruction reads Rs1
//  Rs2UsedD     in   1       ID instruction reads Rs2
//  PCSelectE    in   1       taken branch resolved in EX
//  JtypeE       in   1       JAL/JALR in EX
//  IMemBusy     in   1       instruction fetch not ready
//  DMemBusy     in   1       data memory not ready for MEM-stage access
//  StallF, StallD, StallE, StallM  out 1   hold IF/PC, IF/ID, ID/EX, EX/MEM registers
//  FlushD, FlushE, FlushW          out 1   squash IF/ID, ID/EX (drives masking mux), MEM/WB
//  MemTimeout   out  1       sticky watchdog flag
//  StallCount   out  CNT_W   cycles with StallF=1 (saturating)
//  FlushCount   out  CNT_W   redirects taken (saturating)
// BEHAVIOUR
//  - Reset (RESET=1 at edge): state<=RUN, WaitCnt<=0, MemTimeout<=0, counters<=0. While RESET=1
//    outputs forced: all Stall*=0, FlushD=FlushE=FlushW=1; counters do not count.
//  - LoadUse = MemReadE & (RdE!=0) & ((Rs1UsedD & Rs1D==RdE) | (Rs2UsedD & Rs2D==RdE)).
//  - Redirect = PCSelectE | JtypeE. Outputs are Mealy (state + same-cycle inputs), zero latency.
//  - Output priority, first match wins:
//    1 state==ERROR        : all Stall*=1, FlushW=1, FlushD=FlushE=0.
//    2 DMemBusy            : all Stall*=1, FlushW=1 (bubble into WB), FlushD=FlushE=0; redirect and
//                            load-use are held, not acted on.
//    3 Redirect            : FlushD=1, FlushE=1, no stalls; overrides LoadUse and IMemBusy.
//    4 LoadUse | IMemBusy  : StallF=StallD=1, FlushE=1 (one bubble per cycle asserted).
//    5 otherwise           : all 0.
//  - FSM (registered): RUN -DMemBusy-> MEM_WAIT (WaitCnt<=1).
//    MEM_WAIT: DMemBusy & WaitCnt==TIMEOUT_CYCLES-1 -> ERROR, MemTimeout<=1;
//              DMemBusy otherwise -> stay, WaitCnt++; !DMemBusy -> RUN, WaitCnt<=0
//              (that release cycle evaluates priorities 3-5 normally).
//    ERROR: held until RESET; no way out otherwise.
//  - Watchdog trips on the TIMEOUT_CYCLES-th consecutive busy cycle; ERROR outputs from next cycle.
//  - StallCount +1 per non-reset cycle with StallF=1; FlushCount +1 per cycle where priority 3
//    fires. Both saturate at all-ones, never wrap.
//  - RESET mid-MEM_WAIT or ERROR: returns to RUN next cycle regardless of DMemBusy.
// STRUCTURE
//  - hazard_pkg: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2), default params.
//  - Sub-module load_use_detect: pure combinational comparator producing LoadUse; rest inline.
// TESTING
//  - Load-use: MemReadE=1,RdE=5,Rs1D=5,Rs1UsedD=1 one cycle -> StallF=StallD=FlushE=1 that cycle,
//    StallCount=1.
//  - x0 guard: MemReadE=1,RdE=0,Rs1D=0,Rs1UsedD=1 -> all outputs 0.
//  - Redirect+LoadUse same cycle: PCSelectE=1 with load-use match -> FlushD=FlushE=1, StallF=0,
//    FlushCount=1.
//  - DMem wait: DMemBusy=1 for 3 cycles with JtypeE=1 -> 3 cycles all Stall*=1,FlushW=1,FlushD=0;
//    4th cycle DMemBusy=0 -> FlushD=FlushE=1, state RUN.
//  - Watchdog: TIMEOUT_CYCLES=4, DMemBusy=1 held -> MemTimeout=1 after 4th busy edge; drop
//    DMemBusy -> stalls stay 1; assert RESET 1 cycle -> MemTimeout=0, state RUN.
//  - Saturation: CNT_W=3, IMemBusy=1 for 10 cycles -> StallCount stops at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg: state encoding and default parameters for the pipeline    |
// | hazard controller.                                   Revision: 1.0   |
// +----------------------------------------------------------------------+
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hazard_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_REG_AW         = 5;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_use_detect: flags an ID instruction that needs the result of a   |
// | load still in EX (x0 never creates a dependency).    Revision: 1.0   |
// +----------------------------------------------------------------------+
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              i_mem_read_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic              i_rs1_used_d,
  input  logic              i_rs2_used_d,
  output logic              o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_rs1_used_d && (i_rs1_d == i_rd_e);
  assign w_rs2_hit  = i_rs2_used_d && (i_rs2_d == i_rd_e);
  assign o_load_use = i_mem_read_e && (i_rd_e != '0) && (w_rs1_hit || w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer with data-memory wait     |
// | watchdog and saturating stall/flush counters.        Revision: 1.0   |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int REG_AW         = DEF_REG_AW
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemReadE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              Rs1UsedD,
  input  logic              Rs2UsedD,
  input  logic              PCSelectE,
  input  logic              JtypeE,
  input  logic              IMemBusy,
  input  logic              DMemBusy,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  // Wide enough to hold TIMEOUT_CYCLES-1, the last count before tripping.
  localparam int c_WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

  hazard_state_t       r_state;
  hazard_state_t       w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_load_use;
  logic                w_redirect;
  logic                w_redirect_fire;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .i_mem_read_e(MemReadE),
    .i_rd_e      (RdE),
    .i_rs1_d     (Rs1D),
    .i_rs2_d     (Rs2D),
    .i_rs1_used_d(Rs1UsedD),
    .i_rs2_used_d(Rs2UsedD),
    .o_load_use  (w_load_use)
  );

  assign w_redirect = PCSelectE || JtypeE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait_cnt;
    w_timeout_nxt   = r_timeout;
    StallF          = 1'b0;
    StallD          = 1'b0;
    StallE          = 1'b0;
    StallM          = 1'b0;
    FlushD          = 1'b0;
    FlushE          = 1'b0;
    FlushW          = 1'b0;
    w_redirect_fire = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (DMemBusy) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = c_WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (DMemBusy) begin
          if (r_wait_cnt == c_WAIT_LAST) begin
            w_state_nxt   = ST_ERROR;
            w_timeout_nxt = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase

    // A frozen pipe still pushes a bubble into WB so the stalled MEM op is not retired twice.
    if (RESET) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if ((r_state == ST_ERROR) || DMemBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_redirect) begin
      FlushD          = 1'b1;
      FlushE          = 1'b1;
      w_redirect_fire = 1'b1;
    end else if (w_load_use || IMemBusy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redirect_fire && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign MemTimeout = r_timeout;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
